// File: rtl/tetris_pkg.sv
// Shared action codes, FSM states and small helpers for the tetris command feeder.
package tetris_pkg;

  localparam int ACT_W = 3;

  localparam logic [ACT_W-1:0] NOP    = 3'd0;
  localparam logic [ACT_W-1:0] LEFT   = 3'd1;
  localparam logic [ACT_W-1:0] RIGHT  = 3'd2;
  localparam logic [ACT_W-1:0] DOWN   = 3'd3;
  localparam logic [ACT_W-1:0] ROTATE = 3'd4;
  localparam logic [ACT_W-1:0] DROP   = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } state_t;

  // Number of simultaneous button requests in a {drop, rot, left, right} vector.
  function automatic logic [2:0] req_count(input logic [3:0] r);
    req_count = {2'b00, r[0]} + {2'b00, r[1]} + {2'b00, r[2]} + {2'b00, r[3]};
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Small action FIFO: registered pointers and occupancy, head shown combinationally.
module cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int ACT_W = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [ACT_W-1:0]         din,
  input  logic                     pop,
  output logic [ACT_W-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   fill
);
  import tetris_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_LVL = (PW+1)'(DEPTH);
  localparam logic [PW:0]   FILL_ZERO = (PW+1)'(0);
  localparam logic [PW:0]   FILL_ONE = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ZERO = PW'(0);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [ACT_W-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [PW:0]      fill_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (fill_r == FULL_LVL);
  assign empty     = (fill_r == FILL_ZERO);
  assign fill      = fill_r;
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);
  // No bypass: a word written this cycle only becomes the head next cycle.
  assign dout      = empty ? NOP : mem_r[rd_ptr_r];

  // Storage array write port
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; reset discards everything queued
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      fill_r   <= FILL_ZERO;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   fill_r <= fill_r + FILL_ONE;
        2'b01:   fill_r <= fill_r - FILL_ONE;
        default: fill_r <= fill_r;
      endcase
    end
  end

endmodule

// File: rtl/tetris_cmd_feeder.sv
// Writer side of the tetris core instruction port: button edges and gravity
// ticks are arbitrated into action codes and queued for the core.
module tetris_cmd_feeder #(
  parameter int DEPTH          = 8,
  parameter int ACT_W          = 3,
  parameter int GRAVITY_PERIOD = 16,
  parameter int CNT_W          = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     btn_left,
  input  logic                     btn_right,
  input  logic                     btn_rot,
  input  logic                     btn_drop,
  input  logic                     run,
  input  logic                     game_over,
  output logic [ACT_W-1:0]         action,
  output logic                     action_valid,
  input  logic                     action_ready,
  output logic [$clog2(DEPTH):0]   fill,
  output logic [CNT_W-1:0]         ovf_cnt
);
  import tetris_pkg::*;

  localparam logic [CNT_W-1:0] GRAV_LAST = CNT_W'(GRAVITY_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] OVF_MAX   = {CNT_W{1'b1}};

  state_t           state_r;
  logic [3:0]       btn_prev_r;
  logic [3:0]       req_r;        // {drop, rot, left, right}
  logic [CNT_W-1:0] grav_cnt_r;
  logic             grav_pend_r;
  logic [CNT_W-1:0] ovf_cnt_r;

  logic             active_s;
  logic             pop_s;
  logic             room_s;
  logic             push_s;
  logic             grav_push_s;
  logic [ACT_W-1:0] push_code_s;
  logic [2:0]       lost_s;
  logic [CNT_W:0]   ovf_sum_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic             fifo_clr_s;

  // game_over takes the block out of RUN on this very edge, so nothing is queued
  assign active_s     = (state_r == RUN) & ~game_over;
  assign action_valid = (state_r == RUN) & ~fifo_empty_s;
  assign pop_s        = action_valid & action_ready;
  assign room_s       = ~fifo_full_s | pop_s;
  assign fifo_clr_s   = rst | game_over;
  assign ovf_sum_s    = {1'b0, ovf_cnt_r} + {{(CNT_W-2){1'b0}}, lost_s};
  assign ovf_cnt      = ovf_cnt_r;

  // Arbitrate at most one push per cycle and count discarded button requests
  always_comb begin
    push_s      = 1'b0;
    push_code_s = NOP;
    grav_push_s = 1'b0;
    lost_s      = 3'd0;
    if (active_s && room_s) begin
      casez (req_r)
        4'b1???: begin
          push_s      = 1'b1;
          push_code_s = DROP;
          lost_s      = req_count(req_r) - 3'd1;
        end
        4'b01??: begin
          push_s      = 1'b1;
          push_code_s = ROTATE;
          lost_s      = req_count(req_r) - 3'd1;
        end
        4'b001?: begin
          push_s      = 1'b1;
          push_code_s = LEFT;
          lost_s      = req_count(req_r) - 3'd1;
        end
        4'b0001: begin
          push_s      = 1'b1;
          push_code_s = RIGHT;
        end
        default: begin
          if (grav_pend_r) begin
            push_s      = 1'b1;
            push_code_s = DOWN;
            grav_push_s = 1'b1;
          end else begin
            push_s      = 1'b0;
          end
        end
      endcase
    end else if (active_s) begin
      lost_s = req_count(req_r);
    end else begin
      lost_s = 3'd0;
    end
  end

  // Button edge detection: one-cycle request per rising edge
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_prev_r <= 4'b0000;
      req_r      <= 4'b0000;
    end else begin
      btn_prev_r <= {btn_drop, btn_rot, btn_left, btn_right};
      req_r      <= {btn_drop, btn_rot, btn_left, btn_right} & ~btn_prev_r;
    end
  end

  // Gravity timer; a pending DOWN waits until it wins arbitration
  always_ff @(posedge clk) begin
    if (rst) begin
      grav_cnt_r  <= CNT_ZERO;
      grav_pend_r <= 1'b0;
    end else if (active_s) begin
      if (grav_cnt_r == GRAV_LAST) begin
        grav_cnt_r  <= CNT_ZERO;
        grav_pend_r <= 1'b1;
      end else begin
        grav_cnt_r  <= grav_cnt_r + CNT_ONE;
        grav_pend_r <= grav_pend_r & ~grav_push_s;
      end
    end
  end

  // Saturating count of discarded button requests
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_cnt_r <= CNT_ZERO;
    end else if (ovf_sum_s[CNT_W]) begin
      ovf_cnt_r <= OVF_MAX;
    end else begin
      ovf_cnt_r <= ovf_sum_s[CNT_W-1:0];
    end
  end

  // Game state machine; only reset leaves OVER
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else if (game_over) begin
      state_r <= OVER;
    end else begin
      case (state_r)
        IDLE:    state_r <= run ? RUN : IDLE;
        RUN:     state_r <= run ? RUN : PAUSE;
        PAUSE:   state_r <= run ? RUN : PAUSE;
        OVER:    state_r <= OVER;
        default: state_r <= IDLE;
      endcase
    end
  end

  cmd_fifo #(
    .DEPTH (DEPTH),
    .ACT_W (ACT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (fifo_clr_s),
    .push  (push_s),
    .din   (push_code_s),
    .pop   (pop_s),
    .dout  (action),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .fill  (fill)
  );

endmodule
